fetch_unit: RTL and testbench

//  Parametrised instruction fetch stage for the next-generation multi-cycle core.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Number of byte-address bits below one instruction word.
  function automatic int align_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular prefetch buffer of {pc, instr} entries with flush
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - prefetching instruction fetch stage with redirect flush
// Optional FETCH_BYPASS_EN: forward a response straight to the outputs when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          I_clk,
  input  logic          I_reset,
  input  logic          I_take,
  input  logic          I_redirect,
  input  logic [AW-1:0] I_redirect_pc,
  output logic          O_valid,
  output logic [DW-1:0] O_instr,
  output logic [AW-1:0] O_pc,
  input  logic          MEM_ready,
  output logic          MEM_exec,
  output logic [1:0]    MEM_size,
  output logic [AW-1:0] MEM_addr,
  input  logic [DW-1:0] MEM_data_in,
  input  logic          MEM_data_ready
);

  localparam int            AB         = align_bits(DW);
  localparam int            CW         = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] STEP       = AW'(DW / 8);
  localparam logic [AW-1:0] ALIGN_MASK = ~((AW'(1) << AB) - AW'(1));

  fetch_state_t     state, state_nxt;
  logic [AW-1:0]    fetch_pc;
  logic [AW-1:0]    mem_addr;
  logic [AW+DW-1:0] head;
  logic [CW-1:0]    count;
  logic             empty;
  logic             resp;
  logic             bypass;
  logic             push;
  logic             pop;

  // A response only counts when no redirect lands on the same edge.
  assign resp = (state == ST_WAIT) && MEM_data_ready && !I_redirect;
  assign pop  = I_take && !empty && !I_redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass  = resp && empty;
  assign O_valid = !empty || bypass;
  assign O_pc    = !empty ? head[AW+DW-1:DW] : (bypass ? fetch_pc : '0);
  assign O_instr = !empty ? head[DW-1:0] : (bypass ? MEM_data_in : '0);
`else
  assign bypass  = 1'b0;
  assign O_valid = !empty;
  assign O_pc    = empty ? '0 : head[AW+DW-1:DW];
  assign O_instr = empty ? '0 : head[DW-1:0];
`endif

  // A forwarded entry that is consumed immediately never enters the queue.
  assign push = resp && !(bypass && I_take);

  fetch_fifo #(
    .W     (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (I_clk),
    .rst_n (I_reset),
    .push  (push),
    .wdata ({fetch_pc, MEM_data_in}),
    .pop   (pop),
    .flush (I_redirect),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (!I_redirect && MEM_ready && (count < CW'(DEPTH))) state_nxt = ST_REQ;
      ST_REQ:     state_nxt = I_redirect ? ST_DISCARD : ST_WAIT;
      ST_WAIT: begin
        if (MEM_data_ready)  state_nxt = ST_IDLE;
        else if (I_redirect) state_nxt = ST_DISCARD;
      end
      ST_DISCARD: if (MEM_data_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      mem_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (I_redirect)  fetch_pc <= I_redirect_pc & ALIGN_MASK;
      else if (resp)   fetch_pc <= fetch_pc + STEP;
      // Latched at issue so the address stays stable even if a redirect moves fetch_pc.
      if (state == ST_IDLE && state_nxt == ST_REQ) mem_addr <= fetch_pc;
    end
  end

  assign MEM_exec = (state == ST_REQ);
  assign MEM_size = SIZE_WORD;
  assign MEM_addr = mem_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        I_clk = 1'b0;
  logic        I_reset;
  logic        I_take;
  logic        I_redirect;
  logic [15:0] I_redirect_pc;
  logic        O_valid;
  logic [15:0] O_instr;
  logic [15:0] O_pc;
  logic        MEM_ready;
  logic        MEM_exec;
  logic [1:0]  MEM_size;
  logic [15:0] MEM_addr;
  logic [15:0] MEM_data_in = 16'h0;
  logic        MEM_data_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  bit          resp_en;
  int          req_cnt = 0;
  int          rsp_cnt = 0;
  logic [15:0] pend_addr = 16'h0;

  fetch_unit dut (
    .I_clk          (I_clk),
    .I_reset        (I_reset),
    .I_take         (I_take),
    .I_redirect     (I_redirect),
    .I_redirect_pc  (I_redirect_pc),
    .O_valid        (O_valid),
    .O_instr        (O_instr),
    .O_pc           (O_pc),
    .MEM_ready      (MEM_ready),
    .MEM_exec       (MEM_exec),
    .MEM_size       (MEM_size),
    .MEM_addr       (MEM_addr),
    .MEM_data_in    (MEM_data_in),
    .MEM_data_ready (MEM_data_ready)
  );

  always #5 I_clk = ~I_clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory with one-cycle latency; responses can be held back with resp_en.
  always @(negedge I_clk) begin
    if (MEM_exec) begin
      req_cnt   = req_cnt + 1;
      pend_addr = MEM_addr;
    end
  end

  always @(posedge I_clk) begin
    #1;
    MEM_data_ready = 1'b0;
    if (req_cnt != rsp_cnt && resp_en) begin
      MEM_data_ready = 1'b1;
      MEM_data_in    = mem_word(pend_addr);
      rsp_cnt        = rsp_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #2;
  endtask

  task automatic wait_exec(input int limit, output logic [15:0] addr, output bit ok);
    ok   = 1'b0;
    addr = 16'h0;
    for (int i = 0; i < limit; i++) begin
      if (MEM_exec) begin
        addr = MEM_addr;
        ok   = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (O_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  logic [15:0] addrs[$];
  logic [15:0] a;
  bit          ok;
  bit          saw_valid;
  bit          saw_resp;

  initial begin
    I_reset       = 1'b0;
    I_take        = 1'b0;
    I_redirect    = 1'b0;
    I_redirect_pc = 16'h0;
    MEM_ready     = 1'b1;
    resp_en       = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(O_valid), 32'h0);
    check("rst_instr", 32'(O_instr), 32'h0);
    check("rst_pc", 32'(O_pc), 32'h0);
    check("rst_exec", 32'(MEM_exec), 32'h0);
    check("rst_addr", 32'(MEM_addr), 32'h0);
    check("rst_size", 32'(MEM_size), 32'h2);

    // Fill the queue with no consumer.
    I_reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (MEM_exec) addrs.push_back(MEM_addr);
      tick();
    end
    check("fill_nreq", 32'(addrs.size()), 32'd4);
    for (int i = 0; i < 4 && i < addrs.size(); i++)
      check($sformatf("fill_addr%0d", i), 32'(addrs[i]), 32'(2 * i));
    check("fill_valid", 32'(O_valid), 32'h1);
    check("fill_pc", 32'(O_pc), 32'h0);
    check("fill_instr", 32'(O_instr), 32'(mem_word(16'h0)));

    // One pop from a full queue frees a slot for the next sequential fetch.
    I_take = 1'b1;
    tick();
    I_take = 1'b0;
    check("pop_pc", 32'(O_pc), 32'h2);
    check("pop_instr", 32'(O_instr), 32'(mem_word(16'h2)));
    wait_exec(10, a, ok);
    check("pop_exec_seen", 32'(ok), 32'h1);
    check("pop_next_addr", 32'(a), 32'h8);
    repeat (5) tick();

    // Redirect while waiting for a response: response must be discarded.
    I_take = 1'b1;
    tick();
    I_take = 1'b0;
    wait_exec(10, a, ok);
    resp_en = 1'b0;
    check("rdw_exec_seen", 32'(ok), 32'h1);
    check("rdw_req_addr", 32'(a), 32'hA);
    tick();
    I_redirect    = 1'b1;
    I_redirect_pc = 16'h1235;
    tick();
    I_redirect = 1'b0;
    check("rdw_flushed", 32'(O_valid), 32'h0);
    check("rdw_no_exec", 32'(MEM_exec), 32'h0);
    resp_en = 1'b1;
    wait_exec(10, a, ok);
    check("rdw_exec_seen2", 32'(ok), 32'h1);
    check("rdw_new_addr", 32'(a), 32'h1234);
    wait_valid(10, ok);
    check("rdw_valid_seen", 32'(ok), 32'h1);
    check("rdw_pc", 32'(O_pc), 32'h1234);
    check("rdw_instr", 32'(O_instr), 32'(mem_word(16'h1234)));

    // Redirect and take together: the redirect wins.
    I_take        = 1'b1;
    I_redirect    = 1'b1;
    I_redirect_pc = 16'h2000;
    tick();
    I_take     = 1'b0;
    I_redirect = 1'b0;
    check("rt_valid_off", 32'(O_valid), 32'h0);
    wait_valid(20, ok);
    check("rt_valid_seen", 32'(ok), 32'h1);
    check("rt_pc", 32'(O_pc), 32'h2000);
    check("rt_instr", 32'(O_instr), 32'(mem_word(16'h2000)));

    // Address wrap at the top of the address space.
    I_redirect    = 1'b1;
    I_redirect_pc = 16'hFFFE;
    tick();
    I_redirect = 1'b0;
    wait_exec(20, a, ok);
    check("wrap_exec1", 32'(ok), 32'h1);
    check("wrap_addr1", 32'(a), 32'hFFFE);
    tick();
    wait_exec(20, a, ok);
    check("wrap_exec2", 32'(ok), 32'h1);
    check("wrap_addr2", 32'(a), 32'h0000);
    wait_valid(10, ok);
    check("wrap_pc", 32'(O_pc), 32'hFFFE);

    // Empty queue with a consumer waiting: response timing relative to MEM_data_ready.
    MEM_ready     = 1'b0;
    I_redirect    = 1'b1;
    I_redirect_pc = 16'h0000;
    tick();
    I_redirect = 1'b0;
    repeat (6) tick();
    check("byp_empty", 32'(O_valid), 32'h0);
    I_take    = 1'b1;
    MEM_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (MEM_data_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("byp_resp_seen", 32'(ok), 32'h1);
`ifdef FETCH_BYPASS_EN
    check("byp_valid_same", 32'(O_valid), 32'h1);
    check("byp_pc_same", 32'(O_pc), 32'h0);
    check("byp_instr_same", 32'(O_instr), 32'(mem_word(16'h0)));
`else
    check("byp_valid_same", 32'(O_valid), 32'h0);
    tick();
    check("byp_valid_next", 32'(O_valid), 32'h1);
    check("byp_pc_next", 32'(O_pc), 32'h0);
    check("byp_instr_next", 32'(O_instr), 32'(mem_word(16'h0)));
`endif
    repeat (15) tick();
    I_take = 1'b0;

    // Reset while waiting: the late response must not be pushed.
    wait_exec(30, a, ok);
    resp_en = 1'b0;
    check("rstw_exec_seen", 32'(ok), 32'h1);
    tick();
    MEM_ready = 1'b0;
    I_reset   = 1'b0;
    tick();
    tick();
    I_reset = 1'b1;
    resp_en = 1'b1;
    saw_valid = 1'b0;
    saw_resp  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (O_valid) saw_valid = 1'b1;
      if (MEM_data_ready) saw_resp = 1'b1;
      tick();
    end
    check("rstw_late_resp", 32'(saw_resp), 32'h1);
    check("rstw_no_push", 32'(saw_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
